// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard frame receiver with F0/E0 prefix stripping
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] raw_out,
  output logic       raw_valid,
  output logic       released,
  output logic       extended,
  output logic       frame_err
);

  localparam int FCW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  // Bit 0 carries ps2_clk, bit 1 carries ps2_data through the conditioning chain.
  logic [1:0]     r_sync1;
  logic [1:0]     r_sync2;
  logic [1:0]     r_filt;
  logic [FCW-1:0] r_fcnt [2];
  logic           r_clk_q;

  state_t         r_state;
  logic [2:0]     r_bit_cnt;
  logic [7:0]     r_shift;
  logic           r_parity;
  logic           r_f0_pend;
  logic           r_e0_pend;
  logic [TCW-1:0] r_to_cnt;

  logic           w_fe;
  logic           w_bit;
  logic           w_frame_ok;

  assign w_fe       = r_clk_q & ~r_filt[0];
  assign w_bit      = r_filt[1];
  assign w_frame_ok = w_bit & (^{r_shift, r_parity});

  // The filtered value only moves after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1   <= 2'b11;
      r_sync2   <= 2'b11;
      r_filt    <= 2'b11;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
      r_clk_q   <= 1'b1;
    end else begin
      r_sync1 <= {ps2_data, ps2_clk};
      r_sync2 <= r_sync1;
      r_clk_q <= r_filt[0];
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FCW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    raw_valid <= 1'b0;
    frame_err <= 1'b0;
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_f0_pend <= 1'b0;
      r_e0_pend <= 1'b0;
      r_to_cnt  <= '0;
      raw_out   <= '0;
      released  <= 1'b0;
      extended  <= 1'b0;
    end else if (w_fe) begin
      r_to_cnt <= '0;
      case (r_state)
        IDLE: begin
          if (!w_bit) begin
            r_state   <= DATA;
            r_bit_cnt <= '0;
          end else begin
            frame_err <= 1'b1;
            r_f0_pend <= 1'b0;
            r_e0_pend <= 1'b0;
          end
        end
        DATA: begin
          r_shift   <= {w_bit, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) r_state <= PARITY;
        end
        PARITY: begin
          r_parity <= w_bit;
          r_state  <= STOP;
        end
        STOP: begin
          r_state <= IDLE;
          if (!w_frame_ok) begin
            frame_err <= 1'b1;
            r_f0_pend <= 1'b0;
            r_e0_pend <= 1'b0;
          end else if (r_shift == 8'hF0) begin
            r_f0_pend <= 1'b1;
          end else if (r_shift == 8'hE0) begin
            r_e0_pend <= 1'b1;
          end else begin
            raw_out   <= r_shift;
            released  <= r_f0_pend;
            extended  <= r_e0_pend;
            raw_valid <= 1'b1;
            r_f0_pend <= 1'b0;
            r_e0_pend <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end else if (r_state != IDLE) begin
      // A stalled or inhibited keyboard abandons the partial frame here.
      if (r_to_cnt == TCW'(TIMEOUT_CYCLES)) begin
        r_state   <= IDLE;
        r_to_cnt  <= '0;
        frame_err <= 1'b1;
        r_f0_pend <= 1'b0;
        r_e0_pend <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
PS/2 keyboard receiver directly upstream of the ascii scan-code translator. It synchronises and filters the keyboard's ps2_clk/ps2_data lines and deserialises 11-bit frames. It checks parity and stop bits and strips the F0 (break) and E0 (extended) prefixes. Each completed make/break code is presented as an 8-bit raw code, with a one-cycle valid strobe, ready to drive the ascii block's raw_in.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clk/ps2_data change value (min 2).
TIMEOUT_CYCLES, 100000, clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned (2 ms at 50 MHz).

Ports:
clk  input  1  system clock; all logic on posedge clk.
rst  input  1  synchronous, active-high reset.
ps2_clk  input  1  raw keyboard clock, asynchronous, idle high.
ps2_data  input  1  raw keyboard data, asynchronous, idle high.
raw_out  output  8  last accepted scan code (prefixes stripped); feeds ascii raw_in.
raw_valid  output  1  one-cycle pulse when raw_out is updated.
released  output  1  raw_out is a break code (preceded by F0); updated with raw_out.
extended  output  1  raw_out was preceded by E0; updated with raw_out.
frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset (rst=1 at posedge): all outputs 0, FSM=IDLE, shift register 0, F0/E0 pending flags 0, timeout counter 0. Synchroniser and filter state preset to 1 (idle). Reset mid-frame discards the frame with no error pulse.
- Input conditioning: 2-flop synchroniser per line, then a saturating filter per line. The filtered output takes the new value after FILTER_LEN consecutive equal samples.
- A falling edge (fe) is filtered ps2_clk 1->0, registered; exactly one fe per physical edge. All bit sampling uses filtered ps2_data at the fe cycle.
- FSM states:
  - IDLE: on fe, if data=0 go to DATA with bit count 0; otherwise pulse frame_err and stay in IDLE.
  - DATA: on each fe, shift data in LSB-first. After the 8th bit go to PARITY.
  - PARITY: on fe, capture the parity bit and go to STOP.
  - STOP: on fe, check stop=1 and odd parity over data+parity. If both hold, the frame is accepted; otherwise pulse frame_err. Either way return to IDLE.
- Accepted byte handling:
  - 0xF0: set F0-pending; no raw_valid.
  - 0xE0: set E0-pending; no raw_valid.
  - Any other byte:
    - raw_out <= byte;
    - released <= F0-pending;
    - extended <= E0-pending;
    - raw_valid=1 for exactly one cycle, the cycle after the stop-bit fe;
    - clear both pending flags.
  - Pending flags persist across intervening prefixes (E0 F0 xx gives extended=1 and released=1).
- Error/timeout recovery:
  - A frame error clears both pending flags.
  - The timeout counter resets on every fe and counts while FSM≠IDLE.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, pulse frame_err, clear the pending flags.
- Output holding: raw_out, released and extended hold their values until the next accepted non-prefix code. raw_valid and frame_err are never high in the same cycle.
- Host inhibit: ps2_clk held low without edges is not an fe. It is handled only by timeout if mid-frame.

Test Plan:
- Reset then idle lines for 1000 cycles -> raw_out=0x00, raw_valid never asserted, frame_err never asserted.
- Send frame 0x1C (start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1), FILTER_LEN=4 -> exactly one raw_valid pulse the cycle after the stop fe; raw_out=0x1C, released=0, extended=0; raw_out holds 0x1C afterwards.
- Send 0xF0 (parity 1) then 0x1C -> no pulse after 0xF0; a single pulse after 0x1C with released=1. Then send 0x5A (parity 1) -> raw_out=0x5A, released=0.
- Send E0, F0, 0x75 -> a single raw_valid with raw_out=0x75, extended=1, released=1.
- Send 0x1C with parity 1 -> frame_err pulse, no raw_valid, raw_out unchanged. Next, a correct 0x5A is accepted normally.
- Glitch and timeout:
  - Inject 2-cycle low glitches on ps2_clk (FILTER_LEN=4) -> no fe, no state change.
  - Send 5 bits then stop, with TIMEOUT_CYCLES=200 -> frame_err at cycle 200 after the last fe. The next full 0x1C frame is decoded correctly.
  - Assert rst mid-frame -> outputs 0, no frame_err.
